// File: rtl/hazard_filt_pkg.sv
// Shared types and helpers for the hazard glitch filter.
// Holds the FSM state enum, default stability length and counter-width helper.
package hazard_filt_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_RISE_PEND = 2'd1,
      S_HIGH      = 2'd2,
      S_FALL_PEND = 2'd3
   } state_e;

   localparam int STABLE_DEF = 4;

   // Bits needed to hold values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hazard_glitch_filter_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports: clk, rst_n (async, active-low), d (async in), q (synchronised out).
module sync_2ff
#(
   parameter int W = 1
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/hazard_glitch_filter.sv
// Synchronises a combinational level, rejects pulses shorter than
// STABLE_CYCLES clocks, and emits a clean level plus rise/fall strobes.
// Ports: clk, rst_n (async, active-low), sig_in (async level),
//   glitch_clr (sync clear), filt_out, rise_pulse, fall_pulse, glitch_cnt.
// Build option: define GLITCH_COUNT_EN to build the rejected-glitch
//   counter; otherwise glitch_cnt is tied to 0 and glitch_clr ignored.
module hazard_glitch_filter
   import hazard_filt_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_DEF,
   parameter int GLITCH_W      = 8
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sig_in,
   input  logic                glitch_clr,
   output logic                filt_out,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int CW = cnt_width(STABLE_CYCLES);

   // Count value at which the next matching sample completes the run.
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sig_s;
   state_e        state;
   logic [CW-1:0] cnt;

   sync_2ff #(
      .W (1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig_in),
      .q     (sig_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_LOW;
         cnt        <= '0;
         filt_out   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         unique case (state)
            S_LOW: begin
               if (sig_s) begin
                  state <= S_RISE_PEND;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            S_RISE_PEND: begin
               if (!sig_s) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= S_HIGH;
                  cnt        <= '0;
                  filt_out   <= 1'b1;
                  rise_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!sig_s) begin
                  state <= S_FALL_PEND;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            S_FALL_PEND: begin
               if (sig_s) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= S_LOW;
                  cnt        <= '0;
                  filt_out   <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state    <= S_LOW;
               cnt      <= '0;
               filt_out <= 1'b0;
            end
         endcase
      end
   end

`ifdef GLITCH_COUNT_EN

   localparam logic [GLITCH_W-1:0] GC_MAX = '1;

   // A pending run broken before completion is one rejected glitch.
   logic glitch;

   always_comb begin
      glitch = 1'b0;
      if (state == S_RISE_PEND && !sig_s)
         glitch = 1'b1;
      if (state == S_FALL_PEND && sig_s)
         glitch = 1'b1;
   end

   // Clear has priority over a coincident glitch event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         glitch_cnt <= '0;
      else if (glitch_clr)
         glitch_cnt <= '0;
      else if (glitch && glitch_cnt != GC_MAX)
         glitch_cnt <= glitch_cnt + 1'b1;
   end

`else

   logic unused_clr;

   assign unused_clr = glitch_clr;
   assign glitch_cnt = '0;

`endif

endmodule

// File: tb/tb_hazard_glitch_filter.sv
// Directed bench for hazard_glitch_filter: latency, rejection,
// glitch counting, saturation and asynchronous reset behaviour.
module tb_hazard_glitch_filter;

`ifdef GLITCH_COUNT_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       sig_in;
   logic       glitch_clr;
   logic       filt_out;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [7:0] glitch_cnt;

   logic       sig_in2;
   logic       glitch_clr2;
   logic       filt2;
   logic       rise2;
   logic       fall2;
   logic [1:0] gc2;

   int total;
   int bad;

   hazard_glitch_filter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .glitch_clr (glitch_clr),
      .filt_out   (filt_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .glitch_cnt (glitch_cnt)
   );

   hazard_glitch_filter #(
      .GLITCH_W (2)
   ) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in2),
      .glitch_clr (glitch_clr2),
      .filt_out   (filt2),
      .rise_pulse (rise2),
      .fall_pulse (fall2),
      .glitch_cnt (gc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Release reset with sig_in held high; rise must land on E5.
   task automatic rise_seq(input string tg);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         @(negedge clk);
         chk({tg, "_filt"}, 32'(filt_out), 32'(e >= 5));
         chk({tg, "_rise"}, 32'(rise_pulse), 32'(e == 5));
         chk({tg, "_fall"}, 32'(fall_pulse), 32'd0);
      end
   endtask

   // One-clock high pulse on sig_in, then four quiet cycles.
   task automatic pulse1(input string tg);
      @(negedge clk);
      sig_in = 1'b1;
      @(negedge clk);
      sig_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tg, "_filt"}, 32'(filt_out), 32'd0);
         chk({tg, "_rise"}, 32'(rise_pulse), 32'd0);
      end
   endtask

   task automatic pulse2();
      @(negedge clk);
      sig_in2 = 1'b1;
      @(negedge clk);
      sig_in2 = 1'b0;
      repeat (4) @(negedge clk);
      chk("sat_filt", 32'(filt2), 32'd0);
   endtask

   initial begin
      int falls;
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      sig_in      = 1'b1;
      glitch_clr  = 1'b0;
      sig_in2     = 1'b0;
      glitch_clr2 = 1'b0;

      // Reset state with input already high.
      repeat (2) @(negedge clk);
      chk("rst_filt", 32'(filt_out), 32'd0);
      chk("rst_rise", 32'(rise_pulse), 32'd0);
      chk("rst_gc", 32'(glitch_cnt), 32'd0);

      rise_seq("lat");
      chk("lat_gc", 32'(glitch_cnt), 32'd0);

      // Two-clock low dip while high must be rejected.
      @(negedge clk);
      sig_in = 1'b0;
      repeat (2) @(negedge clk);
      sig_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("dip_filt", 32'(filt_out), 32'd1);
         chk("dip_fall", 32'(fall_pulse), 32'd0);
      end
      chk("dip_gc", 32'(glitch_cnt), 32'(CE));

      // Genuine fall: exactly one strobe.
      sig_in = 1'b0;
      falls  = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (fall_pulse) falls++;
         chk("fall_both", 32'(fall_pulse & rise_pulse), 32'd0);
      end
      chk("fall_cnt", 32'(falls), 32'd1);
      chk("fall_filt", 32'(filt_out), 32'd0);

      glitch_clr = 1'b1;
      @(negedge clk);
      glitch_clr = 1'b0;
      chk("clr_gc", 32'(glitch_cnt), 32'd0);

      for (int k = 0; k < 3; k++) pulse1("p3");
      chk("p3_gc", 32'(glitch_cnt), 32'(3 * CE));

      // Fourth glitch event coincides with clear; clear wins.
      @(negedge clk);
      sig_in = 1'b1;
      @(negedge clk);
      sig_in = 1'b0;
      repeat (2) @(negedge clk);
      glitch_clr = 1'b1;
      @(negedge clk);
      glitch_clr = 1'b0;
      chk("clrwin_gc", 32'(glitch_cnt), 32'd0);
      repeat (2) @(negedge clk);
      chk("clrwin_hold", 32'(glitch_cnt), 32'd0);
      chk("clrwin_filt", 32'(filt_out), 32'd0);

      // Saturation on the 2-bit counter instance.
      for (int k = 0; k < 3; k++) pulse2();
      chk("sat3_gc", 32'(gc2), 32'(3 * CE));
      for (int k = 0; k < 2; k++) pulse2();
      chk("sat5_gc", 32'(gc2), 32'(3 * CE));

      // Reset during rise pending with cnt=3.
      pulse1("pre");
      chk("pre_gc", 32'(glitch_cnt), 32'(CE));
      @(negedge clk);
      sig_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("pend_filt", 32'(filt_out), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gc", 32'(glitch_cnt), 32'd0);
      chk("arst_gc2", 32'(gc2), 32'd0);
      chk("arst_filt", 32'(filt_out), 32'd0);
      chk("arst_rise", 32'(rise_pulse), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("inrst_rise", 32'(rise_pulse), 32'd0);
      end
      rise_seq("rel");

      // Asynchronous reset while high drops filt_out at once.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hi_filt", 32'(filt_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
